uart_frame_rx: RTL and testbench

Frame decoder sitting directly downstream of the UART byte receiver; consumes its one-cycle byte-valid strobe and byte. Recognises frames of the form SOF, LEN, LEN payload bytes, CHK, checks length and XOR checksum, enforces an inter-byte timeout, and buffers the payload. A completed frame is held in an internal buffer, readable by address, until the consumer acknowledges it.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_buf.sv | 40 ++++
 rtl/uart_frame_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_frame_rx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame decoder: FSM state encoding,
// error codes reported on o_Err_Code, and the default start-of-frame byte.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_LEN = 3'd1;
    localparam logic [2:0] ERR_BAD_CHK = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one write port, registered read.
//   i_Clock   : clock
//   i_Reset_n : synchronous active-low reset (read register only)
//   i_Wr_En   : write strobe
//   i_Wr_Addr : write address
//   i_Wr_Data : write data
//   i_Rd_Addr : read address
//   o_Rd_Data : mem[i_Rd_Addr], one clock later
module uart_frame_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Wr_En,
    input  logic [ADDR_W-1:0] i_Wr_Addr,
    input  logic [7:0]        i_Wr_Data,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    // Storage is deliberately left unreset; only the output register clears.
    always_ff @(posedge i_Clock) begin
        if (i_Wr_En)
            r_mem[i_Wr_Addr] <= i_Wr_Data;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n)
            r_rd_data <= 8'h00;
        else
            r_rd_data <= r_mem[i_Rd_Addr];
    end

    assign o_Rd_Data = r_rd_data;

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame decoder. Parses SOF, LEN, LEN payload bytes, CHK from the byte
// receiver strobe, validates length and XOR checksum (LEN ^ payload), enforces
// an inter-byte timeout, and holds a good frame until acknowledged.
//   i_Clock, i_Reset_n     : clock, synchronous active-low reset
//   i_Rx_DV, i_Rx_Byte     : byte strobe and data from the UART receiver
//   o_Frame_Rdy            : a validated frame is held in the buffer
//   o_Frame_Len            : payload length of held frame (0 when none)
//   i_Frame_Ack            : consumer releases the held frame
//   i_Rd_Addr, o_Rd_Data   : buffer read port, 1-cycle latency
//   o_Err, o_Err_Code      : one-cycle error pulse, sticky last error code
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int          MAX_LEN      = 16,
    parameter int          ADDR_W       = 4,
    parameter int          LEN_W        = 5,
    parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
    parameter logic [19:0] TIMEOUT_CLKS = 20'd86800
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Frame_Rdy,
    output logic [LEN_W-1:0]  o_Frame_Len,
    input  logic              i_Frame_Ack,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Err,
    output logic [2:0]        o_Err_Code
);

    state_t             r_state, w_state_nx;
    logic [LEN_W-1:0]   r_len;
    logic [7:0]         r_chk;
    logic [ADDR_W-1:0]  r_idx;
    logic [19:0]        r_cnt;
    logic               r_Err;
    logic [2:0]         r_Err_Code;

    logic               w_err;
    logic [2:0]         w_err_code;
    logic               w_wr_en;
    logic               w_bad_len;
    logic               w_last;
    logic               w_expire;
    logic               w_active_nx;

    assign w_bad_len   = (i_Rx_Byte == 8'h00) || (int'(i_Rx_Byte) > MAX_LEN);
    assign w_last      = (LEN_W'(r_idx) + LEN_W'(1)) == r_len;
    assign w_expire    = (r_cnt == TIMEOUT_CLKS - 20'd1);
    assign w_active_nx = (w_state_nx == ST_LEN) || (w_state_nx == ST_PAYLOAD) ||
                         (w_state_nx == ST_CHK);

    // A DV on the expiry cycle is handled first, so it always beats the timeout.
    always_comb begin
        w_state_nx = r_state;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        w_wr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Rx_DV && i_Rx_Byte == SOF_BYTE)
                    w_state_nx = ST_LEN;
            end
            ST_LEN: begin
                if (i_Rx_DV) begin
                    if (w_bad_len) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_BAD_LEN;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_state_nx = ST_PAYLOAD;
                    end
                end else if (w_expire) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (i_Rx_DV) begin
                    w_wr_en = 1'b1;
                    if (w_last)
                        w_state_nx = ST_CHK;
                end else if (w_expire) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == r_chk) begin
                        w_state_nx = ST_HOLD;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = ERR_BAD_CHK;
                        w_state_nx = ST_IDLE;
                    end
                end else if (w_expire) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Ack takes priority: a coincident byte is dropped quietly.
                if (i_Frame_Ack) begin
                    w_state_nx = ST_IDLE;
                end else if (i_Rx_DV) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVERRUN;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_chk      <= 8'h00;
            r_idx      <= '0;
            r_cnt      <= 20'd0;
            r_Err      <= 1'b0;
            r_Err_Code <= ERR_NONE;
        end else begin
            r_state <= w_state_nx;
            r_Err   <= w_err;
            if (w_err)
                r_Err_Code <= w_err_code;

            // Every in-frame entry happens on a DV, so this also clears on entry.
            if (w_active_nx && !i_Rx_DV)
                r_cnt <= r_cnt + 20'd1;
            else
                r_cnt <= 20'd0;

            if (r_state == ST_LEN && i_Rx_DV && !w_bad_len) begin
                r_len <= i_Rx_Byte[LEN_W-1:0];
                r_chk <= i_Rx_Byte;
                r_idx <= '0;
            end else if (w_wr_en) begin
                r_chk <= r_chk ^ i_Rx_Byte;
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Wr_En   (w_wr_en),
        .i_Wr_Addr (r_idx),
        .i_Wr_Data (i_Rx_Byte),
        .i_Rd_Addr (i_Rd_Addr),
        .o_Rd_Data (o_Rd_Data)
    );

    assign o_Frame_Rdy = (r_state == ST_HOLD);
    assign o_Frame_Len = (r_state == ST_HOLD) ? r_len : '0;
    assign o_Err       = r_Err;
    assign o_Err_Code  = r_Err_Code;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx with a short timeout so the timeout
// cases run quickly. Inputs change 1ns after the rising edge and outputs
// are sampled there too, i.e. they reflect the edge just taken.
module tb_uart_frame_rx;

    localparam int          TO    = 50;
    localparam int          LEN_W = 5;
    localparam int          ADDR_W = 4;

    logic              i_Clock = 1'b0;
    logic              i_Reset_n;
    logic              i_Rx_DV;
    logic [7:0]        i_Rx_Byte;
    logic              o_Frame_Rdy;
    logic [LEN_W-1:0]  o_Frame_Len;
    logic              i_Frame_Ack;
    logic [ADDR_W-1:0] i_Rd_Addr;
    logic [7:0]        o_Rd_Data;
    logic              o_Err;
    logic [2:0]        o_Err_Code;

    int n_chk = 0;
    int n_err = 0;
    int n_pulse = 0;

    uart_frame_rx #(
        .MAX_LEN      (16),
        .ADDR_W       (ADDR_W),
        .LEN_W        (LEN_W),
        .SOF_BYTE     (8'hA5),
        .TIMEOUT_CLKS (20'(TO))
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Rx_DV     (i_Rx_DV),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_Frame_Rdy (o_Frame_Rdy),
        .o_Frame_Len (o_Frame_Len),
        .i_Frame_Ack (i_Frame_Ack),
        .i_Rd_Addr   (i_Rd_Addr),
        .o_Rd_Data   (o_Rd_Data),
        .o_Err       (o_Err),
        .o_Err_Code  (o_Err_Code)
    );

    always #5 i_Clock = ~i_Clock;

    // Counts error pulse cycles (pre-edge value of o_Err).
    always @(posedge i_Clock) if (o_Err) n_pulse++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        tick();
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'h00;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[k]) send(s[k]);
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        i_Rd_Addr = a;
        tick();
        chk(tag, 32'(o_Rd_Data), 32'(exp));
    endtask

    task automatic ack();
        i_Frame_Ack = 1'b1;
        tick();
        i_Frame_Ack = 1'b0;
    endtask

    initial begin
        int p0;
        int first;
        i_Reset_n   = 1'b0;
        i_Rx_DV     = 1'b0;
        i_Rx_Byte   = 8'h00;
        i_Frame_Ack = 1'b0;
        i_Rd_Addr   = '0;
        tick(); tick();
        chk("rst_rdy",  32'(o_Frame_Rdy), 0);
        chk("rst_len",  32'(o_Frame_Len), 0);
        chk("rst_err",  32'(o_Err), 0);
        chk("rst_code", 32'(o_Err_Code), 0);
        chk("rst_rd",   32'(o_Rd_Data), 0);
        i_Reset_n = 1'b1;
        tick();

        // Good frame: chk = 03^11^22^33 = 03
        p0 = n_pulse;
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33});
        chk("good_notrdy", 32'(o_Frame_Rdy), 0);
        send(8'h03);
        chk("good_rdy", 32'(o_Frame_Rdy), 1);
        chk("good_len", 32'(o_Frame_Len), 3);
        rd("good_rd0", 0, 8'h11);
        rd("good_rd1", 1, 8'h22);
        rd("good_rd2", 2, 8'h33);
        chk("good_noerr", 32'(n_pulse - p0), 0);

        // Overrun while holding
        send(8'h99);
        chk("ovr1_err",  32'(o_Err), 1);
        chk("ovr1_code", 32'(o_Err_Code), 4);
        tick();
        chk("ovr1_pulse", 32'(o_Err), 0);
        send(8'h88);
        chk("ovr2_err",  32'(o_Err), 1);
        chk("ovr2_code", 32'(o_Err_Code), 4);
        chk("ovr_rdy",   32'(o_Frame_Rdy), 1);
        rd("ovr_rd0", 0, 8'h11);
        rd("ovr_rd1", 1, 8'h22);
        rd("ovr_rd2", 2, 8'h33);

        // Ack coincident with DV
        p0 = n_pulse;
        i_Frame_Ack = 1'b1;
        send(8'h77);
        i_Frame_Ack = 1'b0;
        chk("ackdv_rdy", 32'(o_Frame_Rdy), 0);
        chk("ackdv_err", 32'(o_Err), 0);
        tick(); tick();
        chk("ackdv_nopulse", 32'(n_pulse - p0), 0);
        // ack outside HOLD ignored
        ack();
        chk("ack_idle_err", 32'(o_Err), 0);

        // Bad checksum: expected 02^AA^55 = FD, sent 00
        send_seq('{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00});
        chk("bchk_err",  32'(o_Err), 1);
        chk("bchk_code", 32'(o_Err_Code), 2);
        chk("bchk_rdy",  32'(o_Frame_Rdy), 0);
        tick();
        chk("bchk_pulse", 32'(o_Err), 0);
        send_seq('{8'hA5, 8'h01, 8'h7E, 8'h7F});
        chk("after_rdy", 32'(o_Frame_Rdy), 1);
        chk("after_len", 32'(o_Frame_Len), 1);
        rd("after_rd0", 0, 8'h7E);
        ack();
        chk("ack_rdy", 32'(o_Frame_Rdy), 0);
        chk("ack_len", 32'(o_Frame_Len), 0);

        // Bad length: 0 and 17, then junk in IDLE
        p0 = n_pulse;
        send_seq('{8'hA5, 8'h00});
        chk("blen0_err",  32'(o_Err), 1);
        chk("blen0_code", 32'(o_Err_Code), 1);
        send_seq('{8'hA5, 8'h11});
        chk("blen17_err",  32'(o_Err), 1);
        chk("blen17_code", 32'(o_Err_Code), 1);
        send(8'h3C);
        tick(); tick();
        chk("blen_pulses", 32'(n_pulse - p0), 2);
        // MAX_LEN exactly is legal: len 16, chk 10 ^ 0..F = 10
        send_seq('{8'hA5, 8'h10});
        for (int k = 0; k < 16; k++) send(8'(k));
        send(8'h10);
        chk("max_rdy", 32'(o_Frame_Rdy), 1);
        chk("max_len", 32'(o_Frame_Len), 16);
        rd("max_rd15", 15, 8'h0F);
        ack();

        // Timeout fires exactly TO cycles after last byte
        send_seq('{8'hA5, 8'h04, 8'h10});
        first = -1;
        for (int k = 1; k <= TO + 5; k++) begin
            tick();
            if (o_Err && first < 0) first = k;
        end
        chk("to_cycle", 32'(first), 32'(TO));
        chk("to_code",  32'(o_Err_Code), 3);
        chk("to_rdy",   32'(o_Frame_Rdy), 0);

        // DV on the expiry cycle wins; chk = 04^10^20^30^40 = 44
        p0 = n_pulse;
        send_seq('{8'hA5, 8'h04, 8'h10});
        for (int k = 1; k < TO; k++) tick();
        send(8'h20);
        chk("to_edge_err", 32'(o_Err), 0);
        send_seq('{8'h30, 8'h40, 8'h44});
        chk("to_edge_rdy", 32'(o_Frame_Rdy), 1);
        chk("to_edge_len", 32'(o_Frame_Len), 4);
        chk("to_edge_nopulse", 32'(n_pulse - p0), 0);
        ack();

        // Reset mid-payload
        p0 = n_pulse;
        send_seq('{8'hA5, 8'h05, 8'h01});
        i_Reset_n = 1'b0;
        tick();
        i_Reset_n = 1'b1;
        chk("mrst_rdy",  32'(o_Frame_Rdy), 0);
        chk("mrst_len",  32'(o_Frame_Len), 0);
        chk("mrst_err",  32'(o_Err), 0);
        chk("mrst_code", 32'(o_Err_Code), 0);
        chk("mrst_rd",   32'(o_Rd_Data), 0);
        // chk = 01^42 = 43
        send_seq('{8'hA5, 8'h01, 8'h42, 8'h43});
        chk("mrst_new_rdy", 32'(o_Frame_Rdy), 1);
        chk("mrst_new_len", 32'(o_Frame_Len), 1);
        rd("mrst_new_rd0", 0, 8'h42);
        chk("mrst_nopulse", 32'(n_pulse - p0), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
